// File: rtl/mem_arb2_if.sv
// Native mem_valid/mem_ready bus bundle. One instance per bus segment:
// the requesting side uses the master modport, the responding side the slave modport.
interface mem_arb2_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter for the native memory bus, with a per-access
// watchdog that force-completes hung accesses and raises a sticky flag.
module mem_arb2 #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hdead_beef
) (
   input  logic            clk,
   input  logic            reset_,
   mem_arb2_if.slave       m0,
   mem_arb2_if.slave       m1,
   mem_arb2_if.master      s,
   output logic [1:0]      grant,
   output logic            timeout_err,
   output logic            timeout_id,
   input  logic            timeout_clr
);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic          last;
   logic          first;
   logic [CW-1:0] cnt;

   logic          busy;
   logic          gid;
   logic          tmo;
   logic          done;
   logic          win;
   logic [31:0]   rdata_c;

   assign busy = (state == BUSY);
   assign gid  = grant[1];

   // The first BUSY cycle only clears the count, so a forced completion lands
   // TIMEOUT_CYCLES+1 cycles after s.valid rises.
   assign tmo  = busy && (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX) && !s.ready;
   assign done = busy && (s.ready || tmo);
   assign win  = (m0.valid && m1.valid) ? ~last : m1.valid;

   assign s.valid = busy;
   assign s.instr = busy && !gid && m0.instr;
   assign s.addr  = !busy ? '0 : (gid ? m1.addr  : m0.addr);
   assign s.wdata = !busy ? '0 : (gid ? m1.wdata : m0.wdata);
   assign s.wstrb = !busy ? '0 : (gid ? m1.wstrb : m0.wstrb);

   assign rdata_c  = tmo ? TIMEOUT_RDATA : s.rdata;
   assign m0.ready = done && !gid;
   assign m1.ready = done && gid;
   assign m0.rdata = m0.ready ? rdata_c : '0;
   assign m1.rdata = m1.ready ? rdata_c : '0;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state       <= IDLE;
         grant       <= 2'b00;
         last        <= 1'b1;
         first       <= 1'b0;
         cnt         <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= 1'b0;
      end else begin
         if (tmo) begin
            timeout_err <= 1'b1;
            timeout_id  <= gid;
         end else if (timeout_clr) begin
            timeout_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (m0.valid || m1.valid) begin
                  state <= BUSY;
                  grant <= win ? 2'b10 : 2'b01;
                  cnt   <= '0;
                  first <= 1'b1;
               end
            end
            BUSY: begin
               if (done) begin
                  state <= IDLE;
                  grant <= 2'b00;
                  last  <= gid;
               end else if (first) begin
                  first <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed table rows, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arb2;
   localparam int T = 8;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic       timeout_clr;
   logic [1:0] grant;
   logic       timeout_err, timeout_id;

   mem_arb2_if m0 ();
   mem_arb2_if m1 ();
   mem_arb2_if s ();

   mem_arb2 #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(32'hdead_beef)) dut (
      .clk(clk), .reset_(reset_), .m0(m0), .m1(m1), .s(s),
      .grant(grant), .timeout_err(timeout_err), .timeout_id(timeout_id),
      .timeout_clr(timeout_clr));

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Transaction-level reference: owner, cycles since s_valid rose, last owner, flags.
   typedef struct packed {
      logic [1:0]  g;
      logic        sv, si;
      logic [31:0] sa, sw;
      logic [3:0]  ss;
      logic        r0;
      logic [31:0] d0;
      logic        r1;
      logic [31:0] d1;
      logic        te, ti;
   } obs_t;

   obs_t        e, a;
   int          own = -1;
   int          waitn = 0;
   logic        mlast = 1'b1, mterr = 1'b0, mtid = 1'b0;
   logic        mto, mdone;
   logic [31:0] md;

   always @(negedge clk) begin
      a = {grant, s.valid, s.instr, s.addr, s.wdata, s.wstrb,
           m0.ready, m0.rdata, m1.ready, m1.rdata, timeout_err, timeout_id};
      e = '0;
      mto = 1'b0;
      mdone = 1'b0;
      if (!reset_) begin
         own = -1; mlast = 1'b1; mterr = 1'b0; mtid = 1'b0;
      end else begin
         e.te = mterr;
         e.ti = mtid;
         if (own >= 0) begin
            mto   = (waitn == T + 1) && !s.ready;
            mdone = s.ready || mto;
            md    = mto ? 32'hdead_beef : s.rdata;
            e.g   = (own == 1) ? 2'b10 : 2'b01;
            e.sv  = 1'b1;
            e.si  = (own == 0) && m0.instr;
            e.sa  = (own == 1) ? m1.addr  : m0.addr;
            e.sw  = (own == 1) ? m1.wdata : m0.wdata;
            e.ss  = (own == 1) ? m1.wstrb : m0.wstrb;
            if (mdone && own == 0) begin e.r0 = 1'b1; e.d0 = md; end
            if (mdone && own == 1) begin e.r1 = 1'b1; e.d1 = md; end
         end
      end
      chk("cycle", 160'(a), 160'(e));
      if (reset_) begin
         if (mto) begin mterr = 1'b1; mtid = (own == 1); end
         else if (timeout_clr) mterr = 1'b0;
         if (own >= 0) begin
            if (mdone) begin mlast = (own == 1); own = -1; end
            else waitn++;
         end else if (m0.valid || m1.valid) begin
            own   = (m0.valid && m1.valid) ? (mlast ? 0 : 1) : (m1.valid ? 1 : 0);
            waitn = 0;
         end
      end
   end

   typedef struct {
      logic        mst;
      logic [31:0] addr, wdata;
      logic [3:0]  wstrb;
      logic        instr;
      int          lat;
      logic [31:0] rdata;
      int          exp_idx;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_grant;
      logic        exp_instr, exp_te, exp_ti;
   } vec_t;

   vec_t tbl[5];

   task automatic idle_inputs();
      m0.valid = 0; m0.instr = 0; m0.addr = 0; m0.wdata = 0; m0.wstrb = 0;
      m1.valid = 0; m1.instr = 0; m1.addr = 0; m1.wdata = 0; m1.wstrb = 0;
      s.ready = 0; s.rdata = 0; timeout_clr = 0;
   endtask

   task automatic run_row(input vec_t v);
      int   idx, first_sv;
      logic got, other;
      @(posedge clk); #1 idle_inputs(); timeout_clr = 1;
      @(posedge clk); #1 timeout_clr = 0;
      #3 chk("clr", 160'(timeout_err), 160'(0));
      @(posedge clk); #1;
      if (v.mst) begin
         m1.valid = 1; m1.addr = v.addr; m1.wdata = v.wdata; m1.wstrb = v.wstrb; m1.instr = v.instr;
      end else begin
         m0.valid = 1; m0.addr = v.addr; m0.wdata = v.wdata; m0.wstrb = v.wstrb; m0.instr = v.instr;
      end
      idx = -1; first_sv = -1; got = 0; other = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (s.valid) begin idx++; if (first_sv < 0) first_sv = k; end
         s.ready = s.valid && (idx == v.lat);
         s.rdata = v.rdata;
         #3;
         other |= v.mst ? m0.ready : m1.ready;
         if (v.mst ? m1.ready : m0.ready) begin
            got = 1;
            chk("ready_idx", 160'(idx), 160'(v.exp_idx));
            chk("rdata", 160'(v.mst ? m1.rdata : m0.rdata), 160'(v.exp_rdata));
            chk("grant", 160'(grant), 160'(v.exp_grant));
            chk("s_wstrb", 160'(s.wstrb), 160'(v.wstrb));
            chk("s_instr", 160'(s.instr), 160'(v.exp_instr));
            chk("s_addr", 160'(s.addr), 160'(v.addr));
         end
      end
      chk("completed", 160'(got), 160'(1));
      chk("sv_latency", 160'(first_sv), 160'(1));
      chk("other_ready", 160'(other), 160'(0));
      @(posedge clk); #1 idle_inputs();
      #3;
      chk("post_idle", 160'({s.valid, grant, s.wstrb}), 160'(0));
      chk("tmo_flags", 160'({timeout_err, timeout_id}), 160'({v.exp_te, v.exp_ti}));
   endtask

   initial begin
      int   order[$];
      int   n0, n1, bubble_bad;
      logic prev_done, a0, a1, r0s, r1s;
      int   sidx, slat;

      tbl[0] = '{1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 0, 32'h1234_5678,
                 0, 32'h1234_5678, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 32'hf000_0004, 32'ha5, 4'b0001, 1'b1, 2, 32'h0,
                 2, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 32'h200, 32'h0, 4'b0000, 1'b0, 99, 32'h1111_1111,
                 9, 32'hdead_beef, 2'b10, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 32'h300, 32'h0, 4'b0000, 1'b0, 9, 32'hcafe_f00d,
                 9, 32'hcafe_f00d, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 32'h400, 32'h55, 4'b1111, 1'b0, 8, 32'h0bad_f00d,
                 8, 32'h0bad_f00d, 2'b01, 1'b0, 1'b0, 1'b1};

      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sv", 160'(s.valid), 160'(0));
      chk("rst_grant", 160'(grant), 160'(0));
      chk("rst_ready", 160'({m0.ready, m1.ready}), 160'(0));
      chk("rst_flags", 160'({timeout_err, timeout_id}), 160'(0));
      #2 reset_ = 1;

      for (int i = 0; i < 5; i++) run_row(tbl[i]);

      // Reset asserted mid-access drops the bus without a clock edge.
      @(posedge clk); #1 m1.valid = 1; m1.addr = 32'h500;
      repeat (3) @(posedge clk);
      #1 chk("pre_arst_sv", 160'(s.valid), 160'(1));
      #1 reset_ = 0;
      #1;
      chk("arst_sv", 160'(s.valid), 160'(0));
      chk("arst_grant", 160'(grant), 160'(0));
      m1.valid = 0;
      @(negedge clk); #1 reset_ = 1;

      // Both masters contend continuously: strict alternation starting at m0.
      @(posedge clk); #1;
      m0.valid = 1; m0.addr = 32'h1000; m1.valid = 1; m1.addr = 32'h2000;
      n0 = 0; n1 = 0; bubble_bad = 0; prev_done = 0;
      for (int k = 0; k < 100 && (n0 < 4 || n1 < 4); k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (n0 >= 4) m0.valid = 0;
         if (n1 >= 4) m1.valid = 0;
         s.ready = s.valid;
         s.rdata = 32'(k);
         #3;
         if (prev_done && s.valid) bubble_bad++;
         prev_done = m0.ready || m1.ready;
         if (m0.ready) begin order.push_back(0); n0++; end
         if (m1.ready) begin order.push_back(1); n1++; end
      end
      chk("rr_count", 160'(order.size()), 160'(8));
      for (int i = 0; i < order.size() && i < 8; i++) chk("rr_order", 160'(order[i]), 160'(i % 2));
      chk("rr_bubble", 160'(bubble_bad), 160'(0));
      @(posedge clk); #1 idle_inputs();

      // Random traffic; the model checks every cycle.
      a0 = 0; a1 = 0; r0s = 0; r1s = 0; sidx = -1; slat = 0;
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk); #1;
         if (r0s) begin a0 = 0; m0.valid = 0; end
         if (r1s) begin a1 = 0; m1.valid = 0; end
         if (!a0 && $urandom_range(0, 2) == 0) begin
            a0 = 1; m0.valid = 1; m0.addr = $urandom; m0.wdata = $urandom;
            m0.wstrb = 4'($urandom); m0.instr = 1'($urandom);
         end else if (a0 && grant == 2'b01 && $urandom_range(0, 15) == 0) m0.valid = 0;
         if (!a1 && $urandom_range(0, 2) == 0) begin
            a1 = 1; m1.valid = 1; m1.addr = $urandom; m1.wdata = $urandom;
            m1.wstrb = 4'($urandom); m1.instr = 1'($urandom);
         end else if (a1 && grant == 2'b10 && $urandom_range(0, 15) == 0) m1.valid = 0;
         if (s.valid) begin
            if (sidx < 0) begin sidx = 0; slat = $urandom_range(0, 11); end
            s.ready = (sidx == slat);
         end else begin
            sidx = -1; s.ready = 0;
         end
         s.rdata = $urandom;
         timeout_clr = ($urandom_range(0, 7) == 0);
         #3;
         r0s = m0.ready; r1s = m1.ready;
         if (s.valid) sidx++;
      end
      @(posedge clk); #1 idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
